i2c_master_tx: RTL
==================

Name: i2c_master_tx

Overview:
Write-only I2C master for the WM8731 codec control port. It accepts a 24-bit frame (device-address byte, then a 16-bit register word) from the codec configuration logic, then transmits START, 3 bytes MSB-first each followed by an ACK slot, then STOP. It drives i2c_sclk and an open-drain i2c_sdat toward the codec, and reports completion and missing acknowledges upstream.

Parameters:
QUARTER_DIV, 125, clk cycles per quarter SCL period (50 MHz / (4*125) = 100 kHz SCL); legal range 2..4095
FRAME_BYTES, 3, bytes per frame; data_in width = 8*FRAME_BYTES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
data_in  in  24  frame; bit 23 is sent first
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of frame
ack_error  out  1  high if any ACK slot sampled 1; held until next accepted start
i2c_sclk  out  1  SCL, push-pull
i2c_sdat  inout  1  SDA; driven 0 or released (z), never driven 1

Behaviour:
- Reset (async, reset_n=0): state IDLE; i2c_sclk=1; i2c_sdat released; busy=0, done=0, ack_error=0; quarter counter, bit counter and byte counter cleared. Reset mid-frame aborts immediately with no STOP generated.
- Quarter tick: counter 0..QUARTER_DIV-1 runs only while busy; tick on terminal count; counter reloads on state entry.
- States: IDLE, START, BIT, ACK, STOP, GAP.
- IDLE: start=1 latches data_in into shift register, clears ack_error, sets busy next cycle, enters START. start while busy is ignored (no queueing).
- START (2 quarters): pull SDA low with SCL=1 at state entry; SCL stays 1 for both quarters; at end SCL->0, enter BIT.
- BIT (4 quarters per bit): q0 SCL=0, SDA set from shift[23] (0 -> drive low, 1 -> release); q1 SCL=0; q2,q3 SCL=1; SDA stable while SCL high. At end of q3, shift left 1 and increment bit counter; after 8 bits enter ACK.
- ACK (4 quarters): SDA released; SCL low q0-q1, high q2-q3; sample SDA on last clk of q2 ('z' or 1 reads as NACK). NACK sets ack_error and goes to STOP after the slot. ACK goes to the next BIT byte, or to STOP after byte FRAME_BYTES.
- STOP (4 quarters): q0 SCL=0, SDA low; q1,q2 SCL=1, SDA low; q3 release SDA (rises while SCL=1).
- GAP (4 quarters, bus free): SCL=1, SDA released; at end: done=1 for one cycle, busy=0 in the same cycle, enter IDLE.
- Frame length without NACK: 2+3*(32+4)+4+4 = 118 quarters = 14750 clk at default.
- SDA and SCL never change on the same clk edge, except the START fall, which happens while SCL is already stable high.

Test Plan:
- Reset: hold reset_n=0 -> i2c_sclk=1, i2c_sdat=z, busy=0, done=0, ack_error=0; release; no activity without start.
- Normal write: slave ACKs, data_in=24'h340C00 -> START (SDA falls, SCL=1); bits 0011_0100, 0000_1100, 0000_0000 sampled on SCL rises; STOP; done pulse 14750 clk after start; ack_error=0.
- SCL timing: measure 5 consecutive SCL rising edges during data -> constant period 500 clk (100 kHz), high time 250 clk.
- NACK: slave leaves SDA released on the first ACK slot, data_in=24'h34_1E00 -> ack_error=1 after 1 byte, STOP immediately, done after 2+36+4+4=46 quarters; ack_error holds until next start.
- Busy protection: pulse start at cycle 100 of a frame with data_in=24'hFFFFFF -> ignored; frame transmits original data; single done pulse.
- Async reset mid-byte (byte 2, bit 3): reset_n low -> SCL=1, SDA=z in the same cycle without a clk edge; after release, new start transmits a complete, correct frame.

Source files
------------

// File: rtl/i2c_master_tx.sv
// Write-only I2C master for the WM8731 codec control port.
// Sends START, FRAME_BYTES bytes MSB-first (each followed by an ACK slot),
// STOP, then a bus-free gap. SDA is open-drain. It is either driven low or released.
// SDA is registered one clk behind the state decode. A data change therefore never
// coincides with an SCL edge. The only exception is the START fall, which is issued on the
// accepting edge while SCL is already high.
module i2c_master_tx #(
  parameter int QUARTER_DIV = 125,
  parameter int FRAME_BYTES = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [8*FRAME_BYTES-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     ack_error,
  output logic                     i2c_sclk,
  inout  wire                      i2c_sdat
);

  localparam int DW  = 8 * FRAME_BYTES;
  localparam int QW  = 12;
  localparam int BYW = $clog2(FRAME_BYTES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      qidx_q, qidx_d;
  logic [2:0]      bit_q, bit_d;
  logic [BYW-1:0]  byte_q, byte_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            sda_low_q, sda_low_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            tick, qend, sda_is_low;

  assign tick       = (state_q != S_IDLE) && (qcnt_q == QW'(QUARTER_DIV - 1));
  assign qend       = tick && (qidx_q == ((state_q == S_START) ? 2'd1 : 2'd3));
  // A released line (z or pulled high) reads as NACK.
  assign sda_is_low = (i2c_sdat == 1'b0);

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign ack_error = ack_err_q;
  assign i2c_sdat  = sda_low_q ? 1'b0 : 1'bz;

  // Quarter-period counter: idle outside a frame, wraps on every tick
  always_comb begin
    qcnt_d = qcnt_q + QW'(1);
    if (state_q == S_IDLE || tick) qcnt_d = '0;
  end

  // Next-state logic: frame sequencing, bit/byte counting, ACK sampling
  always_comb begin
    state_d   = state_q;
    qidx_d    = tick ? qidx_q + 2'd1 : qidx_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        qidx_d = 2'd0;
        if (start) begin
          shift_d   = data_in;
          ack_err_d = 1'b0;
          bit_d     = 3'd0;
          byte_d    = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (qend) begin
          qidx_d  = 2'd0;
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        if (qend) begin
          shift_d = {shift_q[DW-2:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_ACK: begin
        // Sample on the last clk of q2, just before SCL falls in q3
        if (tick && qidx_q == 2'd2 && !sda_is_low) ack_err_d = 1'b1;
        if (qend) begin
          if (ack_err_q || byte_q == BYW'(FRAME_BYTES - 1)) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + BYW'(1);
            state_d = S_BIT;
          end
        end
      end
      S_STOP: begin
        if (qend) state_d = S_GAP;
      end
      S_GAP: begin
        if (qend) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SDA drive request (applied one clk later through sda_low_q)
  always_comb begin
    sda_low_d = 1'b0;
    case (state_q)
      S_IDLE:  sda_low_d = start;
      S_START: sda_low_d = 1'b1;
      S_BIT:   sda_low_d = ~shift_q[DW-1];
      S_ACK:   sda_low_d = 1'b0;
      S_STOP:  sda_low_d = (qidx_q != 2'd3);
      default: sda_low_d = 1'b0;
    endcase
  end

  // SCL decode: low in the first half of each bit/ACK slot and in STOP q0
  always_comb begin
    i2c_sclk = 1'b1;
    case (state_q)
      S_BIT, S_ACK: i2c_sclk = qidx_q[1];
      S_STOP:       i2c_sclk = (qidx_q != 2'd0);
      default:      i2c_sclk = 1'b1;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      qidx_q    <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= '0;
      sda_low_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qidx_q    <= qidx_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sda_low_q <= sda_low_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Frame shift register (loaded on every accepted start, so no reset needed)
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
